// File: rtl/pcpi_div_param.sv
// RV-M DIV/DIVU/REM/REMU coprocessor on PCPI: XLEN-bit restoring divider resolving BITS_PER_CYCLE quotient bits per cycle.
// Latency T+2+XLEN/BITS_PER_CYCLE (T+2 for divide-by-zero/overflow); no backpressure, dropping pcpi_valid aborts.
module pcpi_div_param #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int DW = 2 * XLEN - 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETUP, ITER, DONE} state_t;

  state_t          state;
  logic            is_rem;
  logic            is_signed;
  logic            outsign;
  logic [XLEN-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] qmsk;
  logic [CW-1:0]   cnt;

  logic insn_match;
  assign insn_match = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) && pcpi_insn[14];

  logic unused_insn;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  logic            rs1_neg, rs2_neg, div0, ovf;
  logic [XLEN-1:0] abs1, abs2, special;
  always_comb begin
    rs1_neg = is_signed & pcpi_rs1[XLEN-1];
    rs2_neg = is_signed & pcpi_rs2[XLEN-1];
    abs1    = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
    abs2    = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
    div0    = (pcpi_rs2 == '0);
    ovf     = is_signed && (pcpi_rs1 == MIN_INT) && (pcpi_rs2 == {XLEN{1'b1}});
    // Divide-by-zero takes precedence over overflow.
    if (div0)
      special = is_rem ? pcpi_rs1 : {XLEN{1'b1}};
    else
      special = is_rem ? '0 : MIN_INT;
  end

  logic [XLEN-1:0] nx_dividend, nx_quot, nx_msk, result;
  logic [DW-1:0]   nx_divisor;
  always_comb begin
    nx_dividend = dividend;
    nx_divisor  = divisor;
    nx_quot     = quotient;
    nx_msk      = qmsk;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (nx_divisor <= {{(XLEN-1){1'b0}}, nx_dividend}) begin
        nx_dividend = nx_dividend - nx_divisor[XLEN-1:0];
        nx_quot     = nx_quot | nx_msk;
      end
      nx_divisor = nx_divisor >> 1;
      nx_msk     = nx_msk >> 1;
    end
    if (is_rem)
      result = outsign ? -nx_dividend : nx_dividend;
    else
      result = outsign ? -nx_quot : nx_quot;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      is_rem     <= 1'b0;
      is_signed  <= 1'b0;
      outsign    <= 1'b0;
      dividend   <= '0;
      divisor    <= '0;
      quotient   <= '0;
      qmsk       <= '0;
      cnt        <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wait  <= 1'b0;
      pcpi_rd    <= '0;
    end else begin
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pcpi_valid && insn_match) begin
            is_rem    <= pcpi_insn[13];
            is_signed <= !pcpi_insn[12];
            pcpi_wait <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            state     <= IDLE;
          end else begin
            dividend <= abs1;
            divisor  <= {abs2, {(XLEN-1){1'b0}}};
            quotient <= '0;
            qmsk     <= MIN_INT;
            outsign  <= is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
            cnt      <= CW'(N);
            if (div0 || ovf) begin
              pcpi_rd    <= special;
              pcpi_wr    <= 1'b1;
              pcpi_ready <= 1'b1;
              pcpi_wait  <= 1'b0;
              state      <= DONE;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            state     <= IDLE;
          end else begin
            dividend <= nx_dividend;
            divisor  <= nx_divisor;
            quotient <= nx_quot;
            qmsk     <= nx_msk;
            cnt      <= cnt - CW'(1);
            // The last iteration's steps feed the result directly so ready lands in DONE.
            if (cnt == CW'(1)) begin
              pcpi_rd    <= result;
              pcpi_wr    <= 1'b1;
              pcpi_ready <= 1'b1;
              pcpi_wait  <= 1'b0;
              state      <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
